// File: rtl/regfile_mp_scoreboard.sv
// Multi-read, dual-write register file with a per-register busy scoreboard.
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic wr0_ok;
    logic wr1_ok;
    logic rsv_ok;

    assign wr0_ok = we0 && (wa0 != '0);
    assign wr1_ok = we1 && (wa1 != '0);
    assign rsv_ok = rsv_en && (rsv_addr != '0);

    // Later assignments win: port 1 over port 0, and a reserve over any write-clear.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr0_ok) begin
            mem_d[wa0]  = wd0;
            busy_d[wa0] = 1'b0;
        end
        if (wr1_ok) begin
            mem_d[wa1]  = wd1;
            busy_d[wa1] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;
            logic              busy;

            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                data = (addr == '0) ? '0 : mem_q[addr];
                busy = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
                // Forwarding is suppressed while reset is held so reads stay zero.
                if (rst && (addr != '0)) begin
                    if (wr1_ok && (wa1 == addr)) begin
                        data = wd1;
                    end else if (wr0_ok && (wa0 == addr)) begin
                        data = wd0;
                    end
                    if (((wr0_ok && (wa0 == addr)) || (wr1_ok && (wa1 == addr))) &&
                        !(rsv_ok && (rsv_addr == addr))) begin
                        busy = 1'b0;
                    end
                end
`endif
            end

            assign rd_data[gi*DATA_W +: DATA_W] = data;
            assign rd_busy[gi]                  = busy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed scoreboard bench: expected reads are queued with stimulus and checked on drain.
module tb_regfile_mp_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0, we1, rsv_en;
    logic [4:0]  wa0, wa1, rsv_addr;
    logic [31:0] wd0, wd1;
    logic [31:0] busy_vec;

    regfile_mp_scoreboard dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
    );

    logic [15:0] rd_addr2;
    logic [63:0] rd_data2;
    logic [3:0]  rd_busy2;
    logic        we0_2, we1_2, rsv_en2;
    logic [3:0]  wa0_2, wa1_2, rsv_addr2;
    logic [15:0] wd0_2, wd1_2;
    logic [15:0] busy_vec2;

    regfile_mp_scoreboard #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4)) dut2 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
        .we0(we0_2), .wa0(wa0_2), .wd0(wd0_2), .we1(we1_2), .wa1(wa1_2), .wd1(wd1_2),
        .rsv_en(rsv_en2), .rsv_addr(rsv_addr2), .busy_vec(busy_vec2)
    );

    typedef struct {
        string       tag;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [4:0] a, input logic [31:0] d, input logic b);
        exp_t e;
        e.tag = tag; e.addr = a; e.data = d; e.busy = b;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd_addr = {e.addr, e.addr};
            #1;
            $display("read %s addr=%0d data0=%h data1=%h busy=%b", e.tag, e.addr,
                     rd_data[31:0], rd_data[63:32], rd_busy);
            check({e.tag, "_d0"}, rd_data[31:0], e.data);
            check({e.tag, "_d1"}, rd_data[63:32], e.data);
            check({e.tag, "_b0"}, rd_busy[0], e.busy);
            check({e.tag, "_b1"}, rd_busy[1], e.busy);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; rsv_en = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; rsv_addr = 0;
    endtask

    logic bypass;

    initial begin
`ifdef REGFILE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        rst = 0; rd_addr = 0; idle();
        rd_addr2 = 0; we0_2 = 0; we1_2 = 0; rsv_en2 = 0;
        wa0_2 = 0; wa1_2 = 0; wd0_2 = 0; wd1_2 = 0; rsv_addr2 = 0;
        #3;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #1;
            check($sformatf("rst_rd_a%0d", a), rd_data, 64'h0);
            check($sformatf("rst_busy_a%0d", a), rd_busy, 2'b00);
        end
        check("rst_busy_vec", busy_vec, 32'h0);
        check("rst_busy_vec2", busy_vec2, 16'h0);
        tick();
        rst = 1;

        // Write r5, then assert reset away from any edge.
        tick();
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
        tick(); idle();
        push("r5_written", 5, 32'hDEADBEEF, 0);
        drain();
        rst = 0;
        push("r5_async_rst", 5, 32'h0, 0);
        drain();
        tick();
        rst = 1;
        tick();

        // Same-address collision: port 1 wins.
        we0 = 1; wa0 = 3; wd0 = 32'h11; we1 = 1; wa1 = 3; wd1 = 32'h22;
        push("r3_pre_edge", 3, bypass ? 32'h22 : 32'h0, 0);
        drain();
        tick(); idle();
        push("r3_post_edge", 3, 32'h22, 0);
        drain();

        // Writes and reserves of r0 are discarded.
        we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 0;
        tick(); idle();
        push("r0_zero", 0, 32'h0, 0);
        drain();
        check("r0_busy_vec", busy_vec, 32'h0);

        // Reserve r7, hold for three edges, then writeback clears it.
        rsv_en = 1; rsv_addr = 7;
        tick(); idle();
        check("r7_busy_vec", busy_vec, 32'h0000_0080);
        push("r7_busy", 7, 32'h0, 1);
        drain();
        tick(); tick();
        check("r7_still_busy", busy_vec[7], 1'b1);
        we1 = 1; wa1 = 7; wd1 = 32'hABCD;
        push("r7_wb_pre", 7, bypass ? 32'hABCD : 32'h0, bypass ? 1'b0 : 1'b1);
        drain();
        tick(); idle();
        push("r7_wb_post", 7, 32'hABCD, 0);
        drain();
        check("r7_busy_vec_clr", busy_vec, 32'h0);

        // Reserve wins over a same-edge write.
        rsv_en = 1; rsv_addr = 9; we0 = 1; wa0 = 9; wd0 = 32'h5;
        push("r9_pre", 9, bypass ? 32'h5 : 32'h0, 0);
        drain();
        tick(); idle();
        push("r9_post", 9, 32'h5, 1);
        drain();
        check("r9_busy_vec", busy_vec, 32'h0000_0200);

        // Re-reserving keeps it busy; one write clears it regardless.
        rsv_en = 1; rsv_addr = 9; we1 = 1; wa1 = 12; wd1 = 32'h1234_5678;
        tick(); idle();
        check("r9_rersv_vec", busy_vec, 32'h0000_0200);
        push("r12_nonbusy_wr", 12, 32'h1234_5678, 0);
        drain();
        we0 = 1; wa0 = 9; wd0 = 32'h66;
        tick(); idle();
        push("r9_cleared", 9, 32'h66, 0);
        drain();
        check("r9_busy_vec_clr", busy_vec, 32'h0);

        // Wide configuration: four ports, 16-bit data, 16 registers.
        for (int i = 1; i <= 15; i += 2) begin
            we0_2 = 1; wa0_2 = 4'(i); wd0_2 = 16'(16'h1000 + i);
            we1_2 = (i + 1 <= 15); wa1_2 = 4'(i + 1); wd1_2 = 16'(16'h1000 + i + 1);
            tick();
        end
        we0_2 = 0; we1_2 = 0;
        rsv_en2 = 1; rsv_addr2 = 15;
        tick();
        rsv_en2 = 0;
        rd_addr2 = {4'd15, 4'd11, 4'd6, 4'd1};
        #1;
        $display("read4 data=%h busy=%b busy_vec=%h", rd_data2, rd_busy2, busy_vec2);
        check("w4_p0", rd_data2[15:0], 16'h1001);
        check("w4_p1", rd_data2[31:16], 16'h1006);
        check("w4_p2", rd_data2[47:32], 16'h100B);
        check("w4_p3", rd_data2[63:48], 16'h100F);
        check("w4_busy", rd_busy2, 4'b1000);
        check("w4_busy_vec", busy_vec2, 16'h8000);
        rd_addr2 = {4'd0, 4'd14, 4'd2, 4'd8};
        #1;
        check("w4b_all", rd_data2, {16'h0, 16'h100E, 16'h1002, 16'h1008});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
- Parametrised successor to the single-write-port 32x32 register file, for the pipelined core's decode stage.
- Provides NUM_RD combinational read ports and two write ports (WB0, WB1) with fixed collision priority.
- Adds a per-register busy scoreboard for hazard detection: set at issue, cleared at writeback.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  busy flag of the register addressed by each read port.
- we0  in  1  write enable, port 0.
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1.
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- rsv_en  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  ADDR_W  destination register to reserve.
- busy_vec  out  2**ADDR_W  full scoreboard; bit 0 is always 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers and all busy bits clear to 0 immediately, without waiting for a clock edge;
  - rd_data and rd_busy are therefore 0 for every address, and busy_vec is 0;
  - writes and reserves are ignored while rst=0;
  - reset asserted mid-operation discards all pending reservations.
- Writes: registered on the rising edge of clk.
  - Port 0 writes when we0=1 and wa0!=0; port 1 writes when we1=1 and wa1!=0.
  - Both ports enabled with the same nonzero address: wd1 is stored and wd0 is dropped.
  - Writes to address 0 are discarded.
- Reads: combinational, zero latency.
  - Address 0 reads 0.
  - Otherwise the port returns the stored value, or the same-cycle forwarded value (see Optional Feature).
- Scoreboard, per register r != 0, evaluated at the clock edge in this priority order:
  1. rsv_en=1 and rsv_addr=r -> busy[r] set to 1. A reserve wins over a same-cycle write to r, because it belongs to a newer producer.
  2. Otherwise a write to r on either port -> busy[r] cleared to 0.
  3. Otherwise busy[r] holds.
- rsv_addr=0 is ignored.
- Reserving an already-busy register keeps it busy. There is no reservation counting: one write clears it.
- rd_busy[k] = busy[rd_addr port k], combinational from the registered busy bits.
  - Under BYPASS: a same-cycle write to that address forces rd_busy[k] to 0, unless a same-cycle reserve targets the same address.
- A write to a non-busy register is legal: data updates and busy stays 0.
- No other state. Depth wrap-around does not occur: every address in 0..2**ADDR_W-1 is valid.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - a read whose address equals an enabled nonzero write address in the same cycle returns that write data combinationally (write-through);
  - port 1's data has priority over port 0's;
  - rd_busy is bypassed as described under Behaviour.
- Undefined:
  - reads return only the stored contents, so the new value is visible from the cycle after the edge;
  - rd_busy reflects registered busy bits only.

Test Plan:
- Reset, then read all addresses on every port -> rd_data=0, rd_busy=0, busy_vec=0. Pulse rst low mid-run after writing 0xDEADBEEF to r5 -> r5 reads 0 immediately, without a clock edge.
- we0=1, wa0=3, wd0=0x11; we1=1, wa1=3, wd1=0x22, one edge -> r3 reads 0x22.
  - Same cycle with BYPASS: rd_addr=3 -> 0x22 before the edge.
  - Without BYPASS: the old value before the edge, 0x22 after it.
- we0=1, wa0=0, wd0=0xFFFFFFFF; rsv_en=1, rsv_addr=0 -> r0 reads 0, busy_vec[0]=0.
- rsv_en=1, rsv_addr=7 at edge N -> busy_vec[7]=1 and rd_busy=1 for rd_addr=7. At edge N+3, we1=1, wa1=7, wd1=0xABCD -> busy cleared, r7=0xABCD.
- Same edge: rsv_en=1, rsv_addr=9 and we0=1, wa0=9, wd0=0x5 -> r9=0x5 and busy_vec[9]=1 (reserve wins).
- NUM_RD=4, DATA_W=16, ADDR_W=4: write distinct values 0x1000+i to r1..r15, read four addresses simultaneously -> each port returns its own value; busy_vec is 16 bits wide.
